// File: rtl/wave_source_gen.sv
// Multi-channel programmable waveform source: per channel DC / one-shot pulse / periodic rect
// with linear saturating ramps and shadowed timing captured at start.
module wave_source_gen #(
    parameter int NCH    = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 24,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [3:0]            cfg_addr,
    input  logic [CNT_W-1:0]      cfg_wdata,
    input  logic [NCH-1:0]        start,
    input  logic [NCH-1:0]        stop,
    output logic [NCH*DATA_W-1:0] wave_out,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done
);

    typedef enum logic [2:0] {StIdle, StDelay, StRise, StHigh, StFall, StLow} st_e;

    localparam logic signed [DATA_W-1:0] SMax = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMin = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? SMin : SMax;
        return s[DATA_W-1:0];
    endfunction

    // First phase with a nonzero count at or after index 'from' (DELAY=0 .. LOW=4);
    // rect mode wraps back to RISE, pulse mode never uses LOW.
    function automatic st_e seek(input int from, input logic rect,
                                 input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] r,
                                 input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] f,
                                 input logic [CNT_W-1:0] l);
        logic [4:0] nz;
        st_e        res;
        nz  = {l != '0, f != '0, w != '0, r != '0, d != '0};
        res = StIdle;
        if (!rect) nz[4] = 1'b0;
        else if (nz[4:1] == 4'b0) nz = '0;
        for (int i = 4; i >= 0; i--) if (i >= from && nz[i]) res = st_e'(3'(i + 1));
        if (rect && res == StIdle)
            for (int i = 4; i >= 1; i--) if (nz[i]) res = st_e'(3'(i + 1));
        return res;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [1:0]               mode_q;
        logic signed [DATA_W-1:0] iv_q, pv_q, rs_q, fs_q;
        logic [CNT_W-1:0]         dly_q, rise_q, wid_q, fall_q, low_q;
        logic signed [DATA_W-1:0] siv_q, spv_q, srs_q, sfs_q;
        logic [CNT_W-1:0]         sdly_q, srise_q, swid_q, sfall_q, slow_q;
        st_e                      st_q, st_d;
        logic [CNT_W-1:0]         cnt_q, cnt_d, len;
        logic signed [DATA_W-1:0] acc_q, acc_d, liv, lpv, lrs, lfs, wave;
        logic                     done_q, done_d, load, enter, last, rect, run_mode, idle_eff;

        assign rect     = (mode_q == 2'd2);
        assign run_mode = (mode_q == 2'd1) || rect;
        assign load     = start[c] && !stop[c] && run_mode;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q <= '0; iv_q <= '0; pv_q <= '0; rs_q <= '0; fs_q <= '0;
                dly_q <= '0; rise_q <= '0; wid_q <= '0; fall_q <= '0; low_q <= '0;
            end else if (cfg_we && cfg_ch == CH_W'(c)) begin
                case (cfg_addr)
                    4'd0:    mode_q <= cfg_wdata[1:0];
                    4'd1:    iv_q   <= cfg_wdata[DATA_W-1:0];
                    4'd2:    pv_q   <= cfg_wdata[DATA_W-1:0];
                    4'd3:    dly_q  <= cfg_wdata;
                    4'd4:    rise_q <= cfg_wdata;
                    4'd5:    wid_q  <= cfg_wdata;
                    4'd6:    fall_q <= cfg_wdata;
                    4'd7:    low_q  <= cfg_wdata;
                    4'd8:    rs_q   <= cfg_wdata[DATA_W-1:0];
                    4'd9:    fs_q   <= cfg_wdata[DATA_W-1:0];
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                siv_q <= '0; spv_q <= '0; srs_q <= '0; sfs_q <= '0;
                sdly_q <= '0; srise_q <= '0; swid_q <= '0; sfall_q <= '0; slow_q <= '0;
                st_q <= StIdle; cnt_q <= '0; acc_q <= '0; done_q <= 1'b0;
            end else begin
                if (load) begin
                    siv_q <= iv_q; spv_q <= pv_q; srs_q <= rs_q; sfs_q <= fs_q;
                    sdly_q <= dly_q; srise_q <= rise_q; swid_q <= wid_q;
                    sfall_q <= fall_q; slow_q <= low_q;
                end
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                acc_q  <= acc_d;
                done_q <= done_d;
            end
        end

        always_comb begin
            case (st_q)
                StDelay: len = sdly_q;
                StRise:  len = srise_q;
                StHigh:  len = swid_q;
                StFall:  len = sfall_q;
                StLow:   len = slow_q;
                default: len = '0;
            endcase
        end
        assign last = (cnt_q == len - 1'b1);

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            acc_d  = acc_q;
            done_d = 1'b0;
            enter  = 1'b0;
            liv    = load ? iv_q : siv_q;
            lpv    = load ? pv_q : spv_q;
            lrs    = load ? rs_q : srs_q;
            lfs    = load ? fs_q : sfs_q;
            if (stop[c] || !run_mode) begin
                st_d  = StIdle;
                cnt_d = '0;
            end else if (load) begin
                st_d  = seek(0, rect, dly_q, rise_q, wid_q, fall_q, low_q);
                cnt_d = '0;
                enter = 1'b1;
            end else if (st_q != StIdle) begin
                if (last) begin
                    st_d   = seek(int'(st_q), rect, sdly_q, srise_q, swid_q, sfall_q, slow_q);
                    cnt_d  = '0;
                    enter  = 1'b1;
                    done_d = (st_d == StIdle);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Ramps start from the level the previous phase left behind.
            if (enter) begin
                if (st_d == StRise) acc_d = sat_add(liv, lrs);
                else if (st_d == StFall) acc_d = sat_add(lpv, lfs);
            end else if (st_q == StRise) begin
                acc_d = sat_add(acc_q, srs_q);
            end else if (st_q == StFall) begin
                acc_d = sat_add(acc_q, sfs_q);
            end
        end

        // Leaving PULSE/RECT mode makes the channel look idle at once; the state follows.
        assign idle_eff = (st_q == StIdle) || !run_mode;

        always_comb begin
            wave = siv_q;
            if (idle_eff) begin
                wave = iv_q;
            end else begin
                case (st_q)
                    StRise:  wave = last ? spv_q : acc_q;
                    StHigh:  wave = spv_q;
                    StFall:  wave = last ? siv_q : acc_q;
                    default: wave = siv_q;
                endcase
            end
        end

        assign wave_out[c*DATA_W +: DATA_W] = wave;
        assign busy[c]                      = !idle_eff;
        assign done[c]                      = done_q;
    end

endmodule

// File: tb/tb_wave_source_gen.sv
// Scoreboard bench for wave_source_gen: drivers queue cycle-tagged expectations, a monitor
// on the falling edge pops and checks every entry due in the current cycle.
module tb_wave_source_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [3:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic [3:0]  start, stop;
    logic [63:0] wave_out;
    logic [3:0]  busy, done;

    wave_source_gen dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .stop      (stop),
        .wave_out  (wave_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    ch;
        int    wave;
        logic  busy;
        logic  done;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   tr[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin : monitor
        int                 i;
        logic signed [15:0] got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                got = wave_out[sb[i].ch*16 +: 16];
                n_cmp++;
                if (sb[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s ch%0d: check for cycle %0d missed at cycle %0d",
                             sb[i].nm, sb[i].ch, sb[i].cyc, cyc);
                end else if (int'(got) != sb[i].wave || busy[sb[i].ch] !== sb[i].busy ||
                             done[sb[i].ch] !== sb[i].done) begin
                    n_bad++;
                    $display("FAIL %s ch%0d cyc%0d: got wave=%0d busy=%b done=%b, want wave=%0d busy=%b done=%b",
                             sb[i].nm, sb[i].ch, cyc, got, busy[sb[i].ch], done[sb[i].ch],
                             sb[i].wave, sb[i].busy, sb[i].done);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int a, input int d);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_addr  = 4'(a);
        cfg_wdata = 24'(d);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic exp1(input int c, input int ch, input int w, input logic b, input logic d,
                        input string nm);
        exp_t e;
        e.cyc = c; e.ch = ch; e.wave = w; e.busy = b; e.done = d; e.nm = nm;
        sb.push_back(e);
    endtask

    // Busy samples from the global trace, cycle base onward.
    task automatic push_run(input int base, input int ch, input string nm);
        foreach (tr[i]) exp1(base + i, ch, tr[i], 1'b1, 1'b0, nm);
    endtask

    task automatic pulse(input logic [3:0] st, input logic [3:0] sp);
        start = st;
        stop  = sp;
        tick();
        start = '0;
        stop  = '0;
    endtask

    int k;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        start = '0; stop = '0;
        tick();
        for (int c = 0; c < 4; c++) exp1(cyc, c, 0, 1'b0, 1'b0, "in_reset");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) exp1(cyc, c, 0, 1'b0, 1'b0, "after_reset");
        tick();

        // PULSE on ch0
        wr(0, 0, 1); wr(0, 1, 0); wr(0, 2, 100); wr(0, 3, 3); wr(0, 4, 4);
        wr(0, 8, 25); wr(0, 5, 5); wr(0, 6, 2); wr(0, 9, -50);
        wr(0, 12, 999);  // unmapped address, must not disturb anything
        k  = cyc;
        tr = '{0, 0, 0, 25, 50, 75, 100, 100, 100, 100, 100, 100, 50, 0};
        exp1(k, 0, 0, 1'b0, 1'b0, "pulse_pre");
        push_run(k + 1, 0, "pulse");
        exp1(k + 15, 0, 0, 1'b0, 1'b1, "pulse_done");
        exp1(k + 16, 0, 0, 1'b0, 1'b0, "pulse_after");
        pulse(4'b0001, 4'b0000);
        repeat (17) tick();

        // RECT on ch1, ended by stop
        wr(1, 0, 2); wr(1, 1, -10); wr(1, 2, 10); wr(1, 5, 2); wr(1, 7, 3);
        k  = cyc;
        tr = '{10, 10, -10, -10, -10, 10, 10, -10, -10, -10, 10, 10, -10, -10, -10};
        push_run(k + 1, 1, "rect");
        pulse(4'b0010, 4'b0000);
        repeat (14) tick();
        exp1(cyc + 1, 1, -10, 1'b0, 1'b0, "rect_stop");
        pulse(4'b0000, 4'b0010);
        tick();

        // Saturation both ways on ch2
        wr(2, 0, 1); wr(2, 1, 32760); wr(2, 2, -5000); wr(2, 4, 3); wr(2, 8, 100);
        wr(2, 6, 2); wr(2, 9, -30000);
        k  = cyc;
        tr = '{32767, 32767, -5000, -32768, 32760};
        push_run(k + 1, 2, "sat");
        exp1(k + 6, 2, 32760, 1'b0, 1'b1, "sat_done");
        pulse(4'b0100, 4'b0000);
        repeat (7) tick();

        // start and stop together: stays idle
        k = cyc;
        exp1(k + 1, 0, 0, 1'b0, 1'b0, "start_stop");
        exp1(k + 2, 0, 0, 1'b0, 1'b0, "start_stop2");
        pulse(4'b0001, 4'b0001);
        repeat (3) tick();

        // Restart in run cycle 6
        k  = cyc;
        tr = '{0, 0, 0, 25, 50, 75};
        push_run(k + 1, 0, "pre_restart");
        pulse(4'b0001, 4'b0000);
        repeat (5) tick();
        k  = cyc;
        tr = '{0, 0, 0, 25, 50, 75, 100, 100, 100, 100, 100, 100, 50, 0};
        push_run(k + 1, 0, "restart");
        exp1(k + 15, 0, 0, 1'b0, 1'b1, "restart_done");
        pulse(4'b0001, 4'b0000);
        repeat (16) tick();

        // Config write mid-run leaves the run alone
        k = cyc;
        push_run(k + 1, 0, "midwrite");
        exp1(k + 15, 0, 0, 1'b0, 1'b1, "midwrite_done");
        pulse(4'b0001, 4'b0000);
        tick();
        wr(0, 2, 200);
        repeat (16) tick();

        // All channels in one cycle; ch0 now uses PV=200, ch3 is DC
        wr(3, 1, 77);
        k  = cyc;
        tr = '{0, 0, 0, 25, 50, 75, 200, 200, 200, 200, 200, 200, 150, 0};
        push_run(k + 1, 0, "indep_ch0");
        exp1(k + 15, 0, 0, 1'b0, 1'b1, "indep_ch0_done");
        tr = '{10, 10, -10, -10, -10, 10, 10, -10, -10, -10, 10, 10};
        push_run(k + 1, 1, "indep_ch1");
        tr = '{32767, 32767, -5000, -32768, 32760};
        push_run(k + 1, 2, "indep_ch2");
        exp1(k + 6, 2, 32760, 1'b0, 1'b1, "indep_ch2_done");
        for (int i = 0; i < 6; i++) exp1(k + i, 3, 77, 1'b0, 1'b0, "indep_dc");
        pulse(4'b1111, 4'b0000);
        repeat (11) tick();
        exp1(cyc + 1, 1, -10, 1'b0, 1'b0, "mode_to_dc");
        wr(1, 0, 0);
        repeat (6) tick();

        // Asynchronous reset mid-ramp
        k  = cyc;
        tr = '{0, 0, 0, 25};
        push_run(k + 1, 0, "pre_reset");
        pulse(4'b0001, 4'b0000);
        repeat (4) tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) exp1(cyc, c, 0, 1'b0, 1'b0, "reset_midrun");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) exp1(cyc, c, 0, 1'b0, 1'b0, "reset_idle");
        repeat (3) tick();

        foreach (sb[i]) begin
            n_bad++;
            $display("FAIL %s ch%0d: check for cycle %0d never reached", sb[i].nm, sb[i].ch,
                     sb[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
